// File: rtl/mc_array_ctrl.sv
// Sequencer for the 64x64 memristor compute array: turns row write/read requests
// into timed word-line / bit-line phases and returns captured DOUT for reads.
module mc_array_ctrl #(
    parameter int PULSE_CYCLES = 4,
    parameter int ARM_CYCLES   = 1,
    parameter int EVAL_CYCLES  = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [5:0]  req_row_i,
    input  logic [63:0] req_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_data_o,
    output logic        busy_o,
    output logic [31:0] CWLE_o,
    output logic [31:0] CWLO_o,
    output logic [63:0] CBLEN_o,
    output logic [63:0] CBL_o,
    output logic [63:0] CSL_o,
    output logic [63:0] DIN_o,
    output logic [63:0] DINb_o,
    input  logic [63:0] DOUT_i
);

    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] ARM_LD   = 8'(ARM_CYCLES - 1);
    localparam logic [7:0] EVAL_LD  = 8'(EVAL_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, WA_SETUP, WA_ACT, WA_REL, WB_SETUP, WB_ACT, WB_REL,
        R_SETUP, R_ARM, R_EVAL, R_REL, RESP
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [5:0]  row_q, row_d;
    logic [63:0] data_q, data_d;
    logic [63:0] rsp_data_q, rsp_data_d;
    logic [31:0] cwle_q, cwle_d, cwlo_q, cwlo_d;
    logic [63:0] cblen_q, cblen_d, cbl_q, cbl_d, csl_q, csl_d;
    logic [63:0] din_q, din_d, dinb_q, dinb_d;
    logic [63:0] wl;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: if (req_valid_i) begin
                row_d      = req_row_i;
                data_d     = req_data_i;
                rsp_data_d = '0;
                state_d    = req_write_i ? WA_SETUP : R_SETUP;
            end
            WA_SETUP: begin state_d = WA_ACT; cnt_d = PULSE_LD; end
            WA_ACT:   if (cnt_q == '0) state_d = WA_REL; else cnt_d = cnt_q - 8'd1;
            WA_REL:   state_d = WB_SETUP;
            WB_SETUP: begin state_d = WB_ACT; cnt_d = PULSE_LD; end
            WB_ACT:   if (cnt_q == '0) state_d = WB_REL; else cnt_d = cnt_q - 8'd1;
            WB_REL:   state_d = RESP;
            R_SETUP:  begin state_d = R_ARM; cnt_d = ARM_LD; end
            R_ARM: if (cnt_q == '0) begin
                state_d = R_EVAL;
                cnt_d   = EVAL_LD;
            end else cnt_d = cnt_q - 8'd1;
            // DOUT is taken at the edge that ends the final evaluation cycle
            R_EVAL: if (cnt_q == '0) begin
                state_d    = R_REL;
                rsp_data_d = DOUT_i;
            end else cnt_d = cnt_q - 8'd1;
            R_REL: state_d = RESP;
            RESP: if (rsp_ready_i) begin
                state_d    = IDLE;
                rsp_data_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pin values are decoded from the next state and registered so the array sees clean edges.
    always_comb begin
        wl      = '0;
        cwle_d  = '0;
        cwlo_d  = '0;
        cblen_d = '0;
        cbl_d   = '0;
        csl_d   = '0;
        din_d   = '0;
        dinb_d  = '0;
        if (state_d inside {WA_ACT, WB_ACT, R_ARM, R_EVAL}) wl = 64'd1 << row_d;
        for (int i = 0; i < 32; i++) begin
            cwlo_d[i] = wl[2*i];
            cwle_d[i] = wl[2*i+1];
        end
        case (state_d)
            WA_SETUP, WA_ACT, WA_REL: begin
                cblen_d = '1;
                cbl_d   = ~data_d;
                csl_d   = data_d;
            end
            WB_SETUP, WB_ACT, WB_REL: begin
                cblen_d = '1;
                cbl_d   = ~data_d;
                csl_d   = ~data_d;
            end
            R_SETUP, R_ARM: csl_d = '1;
            R_EVAL, R_REL: begin
                din_d  = data_d;
                dinb_d = ~data_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            row_q      <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            cwle_q     <= '0;
            cwlo_q     <= '0;
            cblen_q    <= '0;
            cbl_q      <= '0;
            csl_q      <= '0;
            din_q      <= '0;
            dinb_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
            cwle_q     <= cwle_d;
            cwlo_q     <= cwlo_d;
            cblen_q    <= cblen_d;
            cbl_q      <= cbl_d;
            csl_q      <= csl_d;
            din_q      <= din_d;
            dinb_q     <= dinb_d;
        end
    end

    assign rsp_valid_o = (state_q == RESP);
    assign req_ready_o = (state_q == IDLE) && !rsp_valid_o;
    assign busy_o      = (state_q != IDLE);
    assign rsp_data_o  = rsp_data_q;
    assign CWLE_o      = cwle_q;
    assign CWLO_o      = cwlo_q;
    assign CBLEN_o     = cblen_q;
    assign CBL_o       = cbl_q;
    assign CSL_o       = csl_q;
    assign DIN_o       = din_q;
    assign DINb_o      = dinb_q;

endmodule

// File: tb/tb_mc_array_ctrl.sv
// Scoreboard bench for mc_array_ctrl: default-timing instance plus a minimum-timing instance.
module tb_mc_array_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // default-timing instance
    logic        req_valid = 0, req_write = 0, rsp_ready = 1;
    logic [5:0]  req_row = 0;
    logic [63:0] req_data = 0, dout, arr_val = 0;
    logic        req_ready, rsp_valid, busy;
    logic [63:0] rsp_data, cblen, cbl, csl, din, dinb;
    logic [31:0] cwle, cwlo;

    mc_array_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_write_i(req_write), .req_row_i(req_row), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .busy_o(busy), .CWLE_o(cwle), .CWLO_o(cwlo), .CBLEN_o(cblen), .CBL_o(cbl),
        .CSL_o(csl), .DIN_o(din), .DINb_o(dinb), .DOUT_i(dout)
    );

    // minimum-timing instance
    logic        f_req_valid = 0, f_req_write = 0, f_rsp_ready = 1;
    logic [5:0]  f_req_row = 0;
    logic [63:0] f_req_data = 0, f_dout, f_arr_val = 0;
    logic        f_req_ready, f_rsp_valid, f_busy;
    logic [63:0] f_rsp_data, f_cblen, f_cbl, f_csl, f_din, f_dinb;
    logic [31:0] f_cwle, f_cwlo;

    mc_array_ctrl #(.PULSE_CYCLES(1), .ARM_CYCLES(1), .EVAL_CYCLES(1)) dut_f (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(f_req_valid), .req_ready_o(f_req_ready),
        .req_write_i(f_req_write), .req_row_i(f_req_row), .req_data_i(f_req_data),
        .rsp_valid_o(f_rsp_valid), .rsp_ready_i(f_rsp_ready), .rsp_data_o(f_rsp_data),
        .busy_o(f_busy), .CWLE_o(f_cwle), .CWLO_o(f_cwlo), .CBLEN_o(f_cblen), .CBL_o(f_cbl),
        .CSL_o(f_csl), .DIN_o(f_din), .DINb_o(f_dinb), .DOUT_i(f_dout)
    );

    // Array model: true data only in the last evaluation cycle, complement otherwise.
    logic [7:0] ev_cnt = 0, f_ev_cnt = 0;
    wire in_eval   = (|{cwle, cwlo}) && (csl == '0) && ((din | dinb) == '1);
    wire f_in_eval = (|{f_cwle, f_cwlo}) && (f_csl == '0) && ((f_din | f_dinb) == '1);
    always @(posedge clk) begin
        ev_cnt   <= in_eval ? ev_cnt + 8'd1 : 8'd0;
        f_ev_cnt <= f_in_eval ? f_ev_cnt + 8'd1 : 8'd0;
    end
    assign dout   = (in_eval && ev_cnt == 8'd1) ? arr_val : ~arr_val;
    assign f_dout = (f_in_eval && f_ev_cnt == 8'd0) ? f_arr_val : ~f_arr_val;

    typedef struct {
        logic [63:0] data;
        time         t_acc;
        int          lat;
    } exp_t;
    exp_t q[$];
    exp_t fq[$];

    // Response monitors: pop on rising rsp_valid, check data and latency.
    logic pv = 0, fpv = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid && !pv) begin
            if (q.size() == 0) chk("rsp_unexpected", 64'(q.size()), 64'd1);
            else begin
                e = q.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_lat", 64'(($time - 5 - e.t_acc) / 10), 64'(e.lat));
            end
        end
        if (f_rsp_valid && !fpv) begin
            if (fq.size() == 0) chk("f_rsp_unexpected", 64'(fq.size()), 64'd1);
            else begin
                e = fq.pop_front();
                chk("f_rsp_data", f_rsp_data, e.data);
                chk("f_rsp_lat", 64'(($time - 5 - e.t_acc) / 10), 64'(e.lat));
            end
        end
        pv  <= rsp_valid;
        fpv <= f_rsp_valid;
    end

    // Word-line sanity on both instances: at most one line, never moving with the columns.
    logic [63:0]  pwl = 0, fpwl = 0;
    logic [319:0] pcol = 0, fpcol = 0;
    always @(negedge clk) begin
        if (rst_n && ({cwle, cwlo} != pwl))
            chk("wl_col_same_cycle", 64'({cblen, cbl, csl, din, dinb} != pcol), 64'd0);
        if (rst_n && ({f_cwle, f_cwlo} != fpwl))
            chk("f_wl_col_same_cycle", 64'({f_cblen, f_cbl, f_csl, f_din, f_dinb} != fpcol), 64'd0);
        chk("wl_onehot", 64'($countones({cwle, cwlo, f_cwle, f_cwlo}) <= 2), 64'd1);
        pwl   <= {cwle, cwlo};
        pcol  <= {cblen, cbl, csl, din, dinb};
        fpwl  <= {f_cwle, f_cwlo};
        fpcol <= {f_cblen, f_cbl, f_csl, f_din, f_dinb};
    end

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send(input logic fast, input logic w, input logic [5:0] r,
                        input logic [63:0] d, input logic [63:0] e, input int lat);
        int i;
        exp_t x;
        if (!fast) begin
            req_write = w; req_row = r; req_data = d; req_valid = 1;
            for (i = 0; i < 64 && !req_ready; i++) @(negedge clk);
            chk("accept_wait", req_ready, 1);
        end else begin
            f_req_write = w; f_req_row = r; f_req_data = d; f_req_valid = 1;
            for (i = 0; i < 64 && !f_req_ready; i++) @(negedge clk);
            chk("f_accept_wait", f_req_ready, 1);
        end
        @(posedge clk);
        x.data = e; x.t_acc = $time; x.lat = lat;
        if (fast) fq.push_back(x); else q.push_back(x);
        @(negedge clk);
        req_valid = 0; f_req_valid = 0;
        req_data = {$urandom, $urandom}; f_req_data = {$urandom, $urandom};
    endtask

    localparam logic [63:0] WD = 64'hA5A5_0000_FFFF_0001;
    localparam logic [63:0] RD = 64'h1234_5678_9ABC_DEF0;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit act;
        logic [63:0] v2, d3;
        rst_n = 0;
        repeat (2) @(negedge clk);
        chk("rst_wl", {cwle, cwlo}, 0);
        chk("rst_cols", cblen | cbl | csl | din | dinb, 0);
        chk("rst_rsp", {rsp_valid, busy}, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_ready", req_ready, 1);
        #3 rst_n = 1;
        repeat (5) @(negedge clk);
        chk("idle_busy", {busy, f_busy, rsp_valid}, 0);

        // write row 5 -> CWLE[2], two 4-cycle pulses
        send(0, 1, 6'd5, WD, 64'd0, 12);
        for (int k = 0; k <= 12; k++) begin
            act = (k >= 1 && k <= 4) || (k >= 7 && k <= 10);
            chk($sformatf("w5_cwle_k%0d", k), cwle, act ? 64'h4 : 64'h0);
            chk("w5_cwlo", cwlo, 0);
            if (k < 12) begin
                chk("w5_cblen", cblen, '1);
                chk("w5_cbl", cbl, ~WD);
                chk($sformatf("w5_csl_k%0d", k), csl, (k < 6) ? WD : ~WD);
                chk("w5_din", din | dinb, 0);
                chk("w5_rsp_valid_lo", rsp_valid, 0);
            end else begin
                chk("w5_cols_idle", cblen | cbl | csl, 0);
                chk("w5_rsp_valid", rsp_valid, 1);
            end
            @(negedge clk);
        end
        chk("w5_back_idle", {req_ready, busy}, 2'b10);

        // read row 0 -> CWLO[0] three cycles
        arr_val = RD;
        send(0, 0, 6'd0, '1, RD, 5);
        for (int k = 0; k <= 5; k++) begin
            chk($sformatf("r0_cwlo_k%0d", k), cwlo, (k >= 1 && k <= 3) ? 64'h1 : 64'h0);
            chk("r0_cwle", cwle, 0);
            chk("r0_cblen_cbl", cblen | cbl, 0);
            chk($sformatf("r0_csl_k%0d", k), csl, (k <= 1) ? '1 : 64'h0);
            chk($sformatf("r0_din_k%0d", k), din, (k >= 2 && k <= 4) ? '1 : 64'h0);
            chk("r0_dinb", dinb, 0);
            @(negedge clk);
        end

        // back-pressure on a read response
        rsp_ready = 0;
        v2 = {$urandom, $urandom};
        arr_val = v2;
        send(0, 0, 6'd17, 64'h0F0F_F0F0_1234_0000, v2, 5);
        repeat (5) @(negedge clk);
        req_write = 1; req_row = 6'd9; req_data = WD; req_valid = 1;
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, v2);
            chk("bp_ready", req_ready, 0);
            chk("bp_busy", busy, 1);
            @(negedge clk);
        end
        rsp_ready = 1;
        @(negedge clk);
        chk("bp_release_ready", req_ready, 1);
        chk("bp_release_valid", rsp_valid, 0);
        chk("bp_release_data", rsp_data, 0);
        send(0, 1, 6'd9, WD, 64'd0, 12);
        chk("bp_accepted_busy", busy, 1);
        repeat (13) @(negedge clk);

        // reset during WB_ACT of a row 63 write
        d3 = {$urandom, $urandom};
        send(0, 1, 6'd63, d3, 64'd0, 12);
        repeat (8) @(negedge clk);
        chk("r63_cwle_hi", cwle, 64'h8000_0000);
        #2 rst_n = 0;
        #1;
        chk("r63_cwle_async", cwle, 0);
        chk("r63_cols_async", cblen | cbl | csl, 0);
        chk("r63_busy", busy, 0);
        chk("r63_ready", req_ready, 1);
        q.delete();
        @(negedge clk);
        #3 rst_n = 1;
        repeat (20) @(negedge clk);
        chk("r63_no_rsp", {rsp_valid, busy}, 0);

        // minimum timing: write row 1 (CWLE[0]), read row 62 (CWLO[31])
        send(1, 1, 6'd1, WD, 64'd0, 6);
        @(negedge clk);
        chk("f_w1_cwle", f_cwle, 64'h1);
        repeat (7) @(negedge clk);
        f_arr_val = {$urandom, $urandom};
        send(1, 0, 6'd62, 64'hFFFF_0000_AAAA_5555, f_arr_val, 4);
        @(negedge clk);
        chk("f_r62_cwlo", f_cwlo, 64'h8000_0000);
        repeat (6) @(negedge clk);
        chk("f_idle", {f_busy, f_rsp_valid}, 0);

        chk("queues_drained", 64'(q.size() + fq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
